// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_DIV_W_DEFAULT = 18;
    localparam int unsigned DIV_DISABLED         = 0;

    // Channel-select width; never below one bit so a single channel still has a port.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider slice: counter, shadow divisor, registered tick and square wave.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W = CLKDIV_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             adv,
    input  logic             resync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_val,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             apply;
    logic             enabled;
    logic             term;

    assign enabled = (act_q != DIV_W'(DIV_DISABLED));
    // >= keeps the counter bounded if a smaller divisor is applied while frozen
    assign term    = (cnt_q >= (act_q - DIV_W'(1)));

    always_comb begin
        cnt_d        = cnt_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        tick_d       = 1'b0;
        sq_d         = sq_q;
        apply        = 1'b0;

        if (resync) begin
            cnt_d = '0;
            sq_d  = 1'b0;
            apply = 1'b1;
        end else if (!adv) begin
            apply = 1'b1;
        end else if (!enabled) begin
            cnt_d = '0;
            apply = 1'b1;
        end else if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
            apply  = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        // Old pending value is consumed before a same-cycle write replaces it.
        if (apply && pend_valid_q) begin
            act_d        = pend_q;
            pend_valid_d = 1'b0;
        end
        if (wr) begin
            pend_d       = wr_val;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tick_q       <= 1'b0;
            sq_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tick_q       <= tick_d;
            sq_q         <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;
    assign busy = pend_valid_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock-enable / divided-clock generator.
// Define CLKDIV_CASCADE_EN to chain channel i>0 off the registered tick of channel i-1.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    parameter  int unsigned DIV_W  = CLKDIV_DIV_W_DEFAULT,
    localparam int unsigned CH_W   = clog2_min1(NUM_CH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              resync,
    input  logic              div_we,
    input  logic [CH_W-1:0]   div_sel,
    input  logic [DIV_W-1:0]  div_val,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] wr;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Out-of-range selects match no channel and are dropped.
        assign wr[gi] = div_we && (div_sel == CH_W'(gi));

`ifdef CLKDIV_CASCADE_EN
        if (gi == 0) begin : g_adv_root
            assign adv[gi] = run;
        end else begin : g_adv_chain
            assign adv[gi] = run & tick[gi-1];
        end
`else
        assign adv[gi] = run;
`endif

        clkdiv_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk    (clk),
            .clr    (clr),
            .adv    (adv[gi]),
            .resync (resync),
            .wr     (wr[gi]),
            .wr_val (div_val),
            .tick   (tick[gi]),
            .sq     (sq[gi]),
            .busy   (busy[gi])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: vector table, directed corners, random vs reference model.
module tb_clkdiv_multi;

    localparam int NCH = 5;
    localparam int DW  = 18;
`ifdef CLKDIV_CASCADE_EN
    localparam bit CASC = 1'b1;
`else
    localparam bit CASC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            clr;
    logic            run, resync, div_we;
    logic [2:0]      div_sel;
    logic [DW-1:0]   div_val;
    logic [NCH-1:0]  tick, sq, busy;

    int checks = 0;
    int fails  = 0;

    int m_cnt [NCH];
    int m_per [NCH];
    int m_pd  [NCH];
    bit m_pv  [NCH];
    bit m_tick[NCH];
    bit m_sq  [NCH];

    typedef struct {
        logic           run, resync, we;
        logic [2:0]     sel;
        logic [DW-1:0]  val;
        logic [NCH-1:0] t, s, b;
    } vec_t;
    vec_t tbl[13];

    clkdiv_multi #(.NUM_CH(NCH), .DIV_W(DW)) dut (
        .clk(clk), .clr(clr), .run(run), .resync(resync), .div_we(div_we),
        .div_sel(div_sel), .div_val(div_val), .tick(tick), .sq(sq), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_per[i] = 0; m_pd[i] = 0;
            m_pv[i] = 0; m_tick[i] = 0; m_sq[i] = 0;
        end
    endtask

    // Reference: period counting in plain integers, one call per clock edge.
    task automatic model_step();
        bit old_tick[NCH];
        bit take, adv_i;
        old_tick = m_tick;
        for (int i = 0; i < NCH; i++) begin
            adv_i = run && (i == 0 || !CASC || old_tick[i-1]);
            take = 1'b1;
            m_tick[i] = 1'b0;
            if (resync) begin
                m_cnt[i] = 0; m_sq[i] = 1'b0;
            end else if (!adv_i) begin
                take = 1'b1;
            end else if (m_per[i] == 0) begin
                m_cnt[i] = 0;
            end else if (m_cnt[i] + 1 >= m_per[i]) begin
                m_cnt[i] = 0; m_tick[i] = 1'b1; m_sq[i] = !m_sq[i];
            end else begin
                m_cnt[i]++; take = 1'b0;
            end
            if (take && m_pv[i]) begin
                m_per[i] = m_pd[i]; m_pv[i] = 1'b0;
            end
            if (div_we && int'(div_sel) == i) begin
                m_pd[i] = int'(div_val); m_pv[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [3*NCH-1:0] model_vec();
        logic [NCH-1:0] t, s, b;
        for (int i = 0; i < NCH; i++) begin
            t[i] = m_tick[i]; s[i] = m_sq[i]; b[i] = m_pv[i];
        end
        return {t, s, b};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("dut_vs_model", 32'({tick, sq, busy}), 32'(model_vec()));
    endtask

    task automatic wr(input int ch, input int val);
        div_we = 1'b1; div_sel = 3'(ch); div_val = DW'(val);
        cycle();
        div_we = 1'b0;
    endtask

    task automatic wait_tick(input int ch, input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            cycle();
            n++;
            if (tick[ch]) return;
        end
        n = maxc + 1000;
    endtask

    task automatic do_reset();
        #2;
        clr = 1'b1;
        run = 1'b0; resync = 1'b0; div_we = 1'b0;
        model_reset();
        #1;
        check("clr_async", 32'({tick, sq, busy}), 32'd0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic rs, input logic we, input int sel,
                                input int val, input int t, input int s, input int b);
        vec_t v;
        v.run = r; v.resync = rs; v.we = we; v.sel = 3'(sel); v.val = DW'(val);
        v.t = NCH'(t); v.s = NCH'(s); v.b = NCH'(b);
        return v;
    endfunction

    initial begin
        int n, t, r1, r2, cnt0, cnt1;
        logic prev, held;
        logic [NCH-1:0] sq_hold;

        // Channel 0 at divide-by-2: apply, run, freeze, ignored write, resync.
        tbl[0]  = mk(1, 0, 1, 0, 2, 0, 0, 1);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 1, 0);
        tbl[9]  = mk(1, 0, 1, 5, 7, 0, 1, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 1, 0);

        clr = 1'b1; run = 1'b0; resync = 1'b0; div_we = 1'b0; div_sel = '0; div_val = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 32'({tick, sq, busy}), 32'd0);
        clr = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run = tbl[i].run; resync = tbl[i].resync; div_we = tbl[i].we;
            div_sel = tbl[i].sel; div_val = tbl[i].val;
            cycle();
            check($sformatf("table_row%0d", i), 32'({tick, sq, busy}),
                  32'({tbl[i].t, tbl[i].s, tbl[i].b}));
        end
        div_we = 1'b0; resync = 1'b0;
        do_reset();

`ifndef CLKDIV_CASCADE_EN
        // ch0=4 and ch1=64: tick period 4, sq[1] period 128, busy clears.
        run = 1'b1;
        wr(0, 4); wr(1, 64);
        cycle();
        check("busy_clear", 32'(busy), 32'd0);
        wait_tick(0, 10, n);
        for (int k = 0; k < 3; k++) begin
            wait_tick(0, 10, n);
            check("ch0_period4", 32'(n), 32'd4);
        end
        t = 0; r1 = -1; r2 = -1; prev = sq[1];
        while (t < 400 && r2 < 0) begin
            cycle(); t++;
            if (sq[1] && !prev) begin
                if (r1 < 0) r1 = t; else r2 = t;
            end
            prev = sq[1];
        end
        check("sq1_period128", 32'(r2 - r1), 32'd128);

        // ch2: div 10, rewrite to 3 at cnt=5; old period completes first.
        wr(2, 10);
        wait_tick(2, 30, n);
        repeat (5) cycle();
        wr(2, 3);
        wait_tick(2, 20, n);
        check("ch2_old_period", 32'(n + 6), 32'd10);
        for (int k = 0; k < 2; k++) begin
            wait_tick(2, 10, n);
            check("ch2_new_period3", 32'(n), 32'd3);
        end

        // ch3: disable while running, sq holds, re-enable at 2.
        wr(3, 5);
        wait_tick(3, 20, n);
        wr(3, 0);
        wait_tick(3, 10, n);
        check("ch3_last_period", 32'(n + 1), 32'd5);
        held = sq[3]; cnt0 = 0;
        repeat (20) begin cycle(); if (tick[3]) cnt0++; end
        check("ch3_disabled_ticks", 32'(cnt0), 32'd0);
        check("ch3_sq_hold", 32'(sq[3]), 32'(held));
        wr(3, 2);
        wait_tick(3, 10, n);
        for (int k = 0; k < 2; k++) begin
            wait_tick(3, 10, n);
            check("ch3_period2", 32'(n), 32'd2);
        end

        // ch4: div 5, freeze 7 cycles at cnt=2, tick 3 cycles after resume.
        wr(4, 5);
        wait_tick(4, 20, n);
        cycle(); cycle();
        run = 1'b0; sq_hold = sq; cnt0 = 0;
        repeat (7) begin cycle(); if (tick != '0) cnt0++; end
        check("freeze_no_tick", 32'(cnt0), 32'd0);
        check("freeze_sq", 32'(sq), 32'(sq_hold));
        run = 1'b1;
        wait_tick(4, 10, n);
        check("resume_latency", 32'(n), 32'd3);

        // resync with ch0=3, ch1=6; out-of-range selects ignored.
        run = 1'b0;
        wr(0, 3); wr(1, 6);
        cycle();
        run = 1'b1;
        repeat (4) cycle();
        resync = 1'b1;
        cycle();
        resync = 1'b0;
        check("resync_out", 32'({tick, sq}), 32'd0);
        cnt0 = 0; cnt1 = 0;
        repeat (24) begin
            cycle();
            if (tick[0]) cnt0++;
            if (tick[1]) begin
                cnt1++;
                check("tick1_align", 32'({tick[0], 1'(cnt0 % 2)}), 32'b10);
            end
        end
        check("tick1_count", 32'(cnt1), 32'd4);
        wr(5, 1); wr(7, 1);
        check("bad_sel_busy", 32'(busy), 32'd0);
        wait_tick(0, 10, n);
        wait_tick(0, 10, n);
        check("bad_sel_ch0_period", 32'(n), 32'd3);
`else
        // Cascade: ch1 counts ch0 ticks, so 10 x 5 = 50 cycles.
        for (int rep = 0; rep < 2; rep++) begin
            run = 1'b0;
            wr(0, 10); wr(1, 5);
            cycle();
            run = 1'b1;
            wait_tick(1, 200, n);
            wait_tick(1, 200, n);
            check("cascade_period50", 32'(n), 32'd50);
            repeat (17) cycle();
            do_reset();
        end
`endif

        // clr mid-operation, then random traffic against the model.
        run = 1'b1;
        wr(0, 3);
        repeat (5) cycle();
        do_reset();
        for (int k = 0; k < 800; k++) begin
            run    = ($urandom_range(0, 9) != 0);
            resync = ($urandom_range(0, 49) == 0);
            div_we = ($urandom_range(0, 4) == 0);
            div_sel = 3'($urandom_range(0, 7));
            div_val = DW'(($urandom_range(0, 15) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7));
            cycle();
        end
        div_we = 1'b0; resync = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised multi-channel clock-enable and divided-clock generator. Successor to the fixed power-of-two ripple divider.
- Each channel has a runtime-programmable integer divisor. Each channel produces:
  - a one-cycle tick enable in the clk domain;
  - a 50%-duty divided square wave.
- Sits at the top of the design and feeds display multiplexing, debounce and memory-test sequencing logic with rates set by software or straps.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- DIV_W, 18, width of each divisor and counter
- CH_W, $clog2(NUM_CH) (min 1), width of channel select (derived, localparam)

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-high
- run  in  1  global count enable; low freezes all counters and outputs
- resync  in  1  synchronous pulse; zeroes all counters for phase alignment
- div_we  in  1  divisor write strobe
- div_sel  in  CH_W  channel addressed by div_we
- div_val  in  DIV_W  divisor value; 0 = channel disabled
- tick  out  NUM_CH  per-channel one-cycle pulse at terminal count
- sq  out  NUM_CH  per-channel square wave, toggles on each tick
- busy  out  NUM_CH  per-channel flag: pending divisor not yet applied

Behaviour:
- Reset (clr high, async): all counters = 0; active and pending divisors = 0; tick = 0; sq = 0; busy = 0.
- Per-channel registers: cnt[DIV_W], act_div[DIV_W], pend_div[DIV_W], pend_valid.
- Counting (run=1, act_div != 0):
  - cnt increments each cycle.
  - When cnt == act_div-1: next cnt = 0, tick registered high for exactly one cycle, sq toggles.
  - Tick period = act_div cycles; sq period = 2*act_div cycles.
  - act_div=1 gives tick every cycle and sq = clk/2.
- Arithmetic: the compare uses act_div-1 in DIV_W bits. Max divisor 2^DIV_W-1. No overflow is possible because cnt wraps at the terminal count.
- Disabled channel (act_div == 0): cnt held at 0, tick = 0, sq holds its last value.
- Divisor write (div_we=1, div_sel < NUM_CH):
  - Loads pend_div and sets pend_valid (busy=1) next cycle.
  - div_sel >= NUM_CH: write ignored.
- Apply rule, glitch-free (pend_valid and one of the three cases below):
  - At the cycle the terminal count fires: act_div <= pend_div, pend_valid cleared.
  - If act_div == 0: applied on the next cycle, with cnt = 0.
  - If run = 0: applied immediately.
- Write to a channel already busy: pend_div overwritten; last write wins.
- Write and terminal count in the same cycle on the same channel: the old pend_div (if any) is applied; the new value becomes pending.
- run = 0: cnt, sq and act_div frozen; tick forced 0. Resuming continues from the frozen cnt.
- resync = 1: all cnt <= 0 next cycle, tick = 0 that cycle, sq <= 0. Pending divisors are applied at the same time. resync has priority over the terminal count.
- Reset mid-operation: immediate async return to reset state. No tick may be emitted in the reset-release cycle.
- Latency: tick and sq are registered outputs, one cycle after the cnt terminal-count compare.

Optional Feature:
- Macro: CLKDIV_CASCADE_EN
- Defined:
  - Channel i>0 advances only on cycles where tick[i-1] was high (the prior-cycle registered tick), instead of every clk.
  - Allows very long periods by chaining channels.
  - Channel 0 is unchanged.
  - run and resync still apply globally.
- Undefined: all channels count clk cycles independently; no cross-channel logic is synthesised.

Decomposition:
- Package clkdiv_pkg:
  - CLKDIV_DIV_W_DEFAULT
  - function clog2_min1
  - localparam DIV_DISABLED = 0
- Sub-module clkdiv_chan:
  - one counter/shadow-divisor/tick/sq slice;
  - ports: clk, clr, adv, resync, wr, wr_val, tick, sq, busy.
- Top clkdiv_multi:
  - generates NUM_CH slices;
  - decodes div_sel;
  - wires the cascade advance under the macro.

Test Plan:
- Reset, write ch0=4, ch1=64, run=1 -> tick[0] every 4 cycles; sq[1] period 128 cycles (matches the legacy q[6]); busy clears within one tick.
- ch2 running at 10, write 3 mid-count at cnt=5 -> next tick still 4 cycles later (old period completes); subsequent ticks every 3 cycles; no short pulse on sq.
- Write ch3=0 while running -> tick[3] stops after the current period; sq[3] holds; rewrite 2 -> ticks resume every 2 cycles.
- run low for 7 cycles at cnt=2 of div 5 -> no ticks, sq frozen; after run high, tick arrives 3 cycles later.
- resync pulse with ch0=3, ch1=6 mid-count -> both cnt 0; tick[1] coincides with every second tick[0] thereafter; div_sel=NUM_CH write leaves all act_div unchanged.
- CLKDIV_CASCADE_EN, ch0=10, ch1=5 -> tick[1] every 50 cycles; assert clr mid-period -> all outputs 0 immediately, counting restarts cleanly after release.
